// File: rtl/multicycle_datapath_if.sv
// ---------------------------------------------------------------------------
// multicycle_datapath_if
//   Shared instruction/data memory port. This port uses a request/ready
//   handshake, so the memory may insert wait states.
//
//   mem_req   : request is active; addr/we/wdata are held until completion
//   mem_we    : 1 = write, 0 = read (valid while mem_req = 1)
//   mem_addr  : word address
//   mem_wdata : store data
//   mem_rdata : read data, valid in the cycle mem_ready = 1
//   mem_ready : completes the current request (may be combinational from req)
//
//   master = core side, slave = memory side.
// ---------------------------------------------------------------------------
interface multicycle_datapath_if #(
  parameter int WIDTH = 24
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// ---------------------------------------------------------------------------
// multicycle_datapath
//   Multi-cycle CPU datapath. It contains the register file, ALU, PC logic
//   and a FETCH/DECODE/EXEC/MEM/WB/HALT sequencer. All instruction and data
//   traffic goes through one shared request/ready memory port.
//
//   Clock     : sole clock, rising edge
//   Resetn    : asynchronous active-low reset
//   mem       : memory port (master side of multicycle_datapath_if)
//   pc        : current PC
//   opcode    : opcode of the latched instruction
//   state     : sequencer state (FETCH=0 .. HALT=5)
//   halted    : core has executed HALT and is stopped
//   ovf_flag  : sticky signed overflow from ADD/SUB/ADDI
//   retired   : retired-instruction counter (wraps at 2^32)
//   wb_valid  : register-write strobe, high for exactly the WB cycle
//   wb_addr   : register index being written
//   wb_data   : data being written
// ---------------------------------------------------------------------------
module multicycle_datapath #(
  parameter int WIDTH    = 24,
  parameter int REG_ADDR = 4,
  parameter int PC_RESET = 10,
  parameter int PC_STEP  = 3,
  parameter int BR_SHIFT = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  multicycle_datapath_if.master mem,
  output logic [WIDTH-1:0]      pc,
  output logic [3:0]            opcode,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  ovf_flag,
  output logic [31:0]           retired,
  output logic                  wb_valid,
  output logic [REG_ADDR-1:0]   wb_addr,
  output logic [WIDTH-1:0]      wb_data
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_SLT = 4'd5;
  localparam logic [3:0] F_SLL = 4'd6;
  localparam logic [3:0] F_SRL = 4'd7;

  localparam int               NREGS   = 1 << REG_ADDR;
  localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(PC_RESET);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              r_state;
  logic [WIDTH-1:0]    r_pc;
  logic [WIDTH-1:0]    r_ir;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_wb_data;
  logic [REG_ADDR-1:0] r_wb_addr;
  logic                r_wb_valid;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [WIDTH-1:0]    r_mem_addr;
  logic [WIDTH-1:0]    r_mem_wdata;
  logic                r_halted;
  logic                r_ovf;
  logic [31:0]         r_retired;
  logic [WIDTH-1:0]    r_regs [NREGS];

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [3:0]          w_op;
  logic [3:0]          w_rs;
  logic [3:0]          w_rt;
  logic [3:0]          w_rd;
  logic [3:0]          w_funct;
  logic [WIDTH-1:0]    w_imm;
  logic [WIDTH-1:0]    w_jaddr;
  logic [REG_ADDR-1:0] w_rs_idx;
  logic [REG_ADDR-1:0] w_rt_idx;
  logic [REG_ADDR-1:0] w_rd_idx;

  assign w_op     = r_ir[WIDTH-1  -: 4];
  assign w_rs     = r_ir[WIDTH-5  -: 4];
  assign w_rt     = r_ir[WIDTH-9  -: 4];
  assign w_rd     = r_ir[WIDTH-13 -: 4];
  assign w_funct  = r_ir[3:0];
  assign w_imm    = {{12{r_ir[WIDTH-13]}}, r_ir[WIDTH-13:0]};
  assign w_jaddr  = {4'b0000, r_ir[WIDTH-5:0]};
  assign w_rs_idx = REG_ADDR'(w_rs);
  assign w_rt_idx = REG_ADDR'(w_rt);
  assign w_rd_idx = REG_ADDR'(w_rd);

  // Register 0 is never written, so it always reads back its reset value 0.
  logic [WIDTH-1:0] w_rf_rs;
  logic [WIDTH-1:0] w_rf_rt;
  assign w_rf_rs = r_regs[w_rs_idx];
  assign w_rf_rt = r_regs[w_rt_idx];

  // -------------------------------------------------------------------------
  // ALU (operands come from the DECODE-latched r_a / r_b)
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_addi;
  logic [4:0]       w_shamt;
  logic             w_shamt_ok;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_alu_wr;

  assign w_sum      = r_a + r_b;
  assign w_diff     = r_a - r_b;
  assign w_addi     = r_a + w_imm;
  assign w_shamt    = r_b[4:0];
  assign w_shamt_ok = int'(w_shamt) < WIDTH;

  // NOTE: every output of a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_wr  = 1'b0;
    case (w_op)
      OP_R: begin
        w_alu_wr = 1'b1;
        case (w_funct)
          F_ADD: begin
            w_alu_res = w_sum;
            w_alu_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
          end
          F_SUB: begin
            w_alu_res = w_diff;
            w_alu_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
          end
          F_AND: w_alu_res = r_a & r_b;
          F_OR:  w_alu_res = r_a | r_b;
          F_XOR: w_alu_res = r_a ^ r_b;
          F_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
          F_SLL: w_alu_res = w_shamt_ok ? (r_a << w_shamt) : '0;
          F_SRL: w_alu_res = w_shamt_ok ? (r_a >> w_shamt) : '0;
          default: w_alu_wr = 1'b0;  // unknown funct: behaves as NOP
        endcase
      end
      OP_ADDI: begin
        w_alu_wr  = 1'b1;
        w_alu_res = w_addi;
        w_alu_ovf = (r_a[WIDTH-1] == w_imm[WIDTH-1]) && (w_addi[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_LW, OP_SW: w_alu_res = w_addi;  // effective address
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next PC for the instructions that finish in EXEC
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_pc_exec;

  assign w_pc_seq = r_pc + STEP;
  assign w_br_tgt = w_pc_seq + (w_imm << BR_SHIFT);

  always_comb begin
    w_pc_exec = w_pc_seq;
    case (w_op)
      OP_BEQ:  w_pc_exec = (r_a == r_b) ? w_br_tgt : w_pc_seq;
      OP_BNE:  w_pc_exec = (r_a != r_b) ? w_br_tgt : w_pc_seq;
      OP_J:    w_pc_exec = w_jaddr;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer. The memory-port outputs are registered and are set up on the
  // edge that enters FETCH or MEM. This keeps them stable through any wait
  // states.
  // -------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_FETCH;
      r_pc        <= PC_INIT;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_wb_data   <= '0;
      r_wb_addr   <= '0;
      r_wb_valid  <= 1'b0;
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= PC_INIT;
      r_mem_wdata <= '0;
      r_halted    <= 1'b0;
      r_ovf       <= 1'b0;
      r_retired   <= '0;
      // NOTE: the register file is reset explicitly. Software relies on
      // every register (not only r0) reading 0 after reset.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_mem_req && mem.mem_ready) begin
            r_ir      <= mem.mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_a     <= w_rf_rs;
          r_b     <= w_rf_rt;
          r_state <= S_EXEC;
        end

        S_EXEC: begin
          r_wb_data <= w_alu_res;
          r_wb_addr <= (w_op == OP_R) ? w_rd_idx : w_rt_idx;
          r_ovf     <= r_ovf | w_alu_ovf;
          if (w_alu_wr) begin
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end else if (w_op == OP_LW || w_op == OP_SW) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_SW);
            r_mem_addr  <= w_alu_res;
            r_mem_wdata <= r_b;
            r_state     <= S_MEM;
          end else if (w_op == OP_HALT) begin
            r_retired <= r_retired + 32'd1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            // Branches, jump, NOP opcodes and R-type with unknown funct.
            r_pc       <= w_pc_exec;
            r_mem_addr <= w_pc_exec;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_retired  <= r_retired + 32'd1;
            r_state    <= S_FETCH;
          end
        end

        S_MEM: begin
          if (r_mem_req && mem.mem_ready) begin
            if (r_mem_we) begin
              r_pc       <= w_pc_seq;
              r_mem_addr <= w_pc_seq;
              r_mem_we   <= 1'b0;
              r_retired  <= r_retired + 32'd1;
              r_state    <= S_FETCH;
            end else begin
              r_wb_data  <= mem.mem_rdata;
              r_wb_valid <= 1'b1;
              r_mem_req  <= 1'b0;
              r_state    <= S_WB;
            end
          end
        end

        S_WB: begin
          if (r_wb_addr != '0) r_regs[r_wb_addr] <= r_wb_data;
          r_wb_valid <= 1'b0;
          r_pc       <= w_pc_seq;
          r_mem_addr <= w_pc_seq;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_retired  <= r_retired + 32'd1;
          r_state    <= S_FETCH;
        end

        S_HALT: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end

        default: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  assign pc       = r_pc;
  assign opcode   = w_op;
  assign state    = r_state;
  assign halted   = r_halted;
  assign ovf_flag = r_ovf;
  assign retired  = r_retired;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_multicycle_datapath.sv
// ---------------------------------------------------------------------------
// tb_multicycle_datapath
//   Directed bench for multicycle_datapath. A 256-word memory model with a
//   programmable ready delay sits on the slave side. Each scenario task loads
//   a small program, runs it and compares the observability outputs against
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_multicycle_datapath;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_datapath_if #(.WIDTH(W)) bus ();

  logic [W-1:0]  pc;
  logic [3:0]    opcode;
  logic [2:0]    state;
  logic          halted;
  logic          ovf_flag;
  logic [31:0]   retired;
  logic          wb_valid;
  logic [3:0]    wb_addr;
  logic [W-1:0]  wb_data;

  multicycle_datapath #(
    .WIDTH(W), .REG_ADDR(4), .PC_RESET(10), .PC_STEP(3), .BR_SHIFT(2)
  ) dut (
    .Clock   (clk),
    .Resetn  (rst_n),
    .mem     (bus),
    .pc      (pc),
    .opcode  (opcode),
    .state   (state),
    .halted  (halted),
    .ovf_flag(ovf_flag),
    .retired (retired),
    .wb_valid(wb_valid),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  logic [W-1:0] tb_mem [256];
  int           wait_n;
  int           wait_cnt;

  assign bus.mem_rdata = tb_mem[bus.mem_addr[7:0]];
  assign bus.mem_ready = bus.mem_req && (wait_cnt >= wait_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wait_cnt <= 0;
    else if (!bus.mem_req || bus.mem_ready)  wait_cnt <= 0;
    else                                     wait_cnt <= wait_cnt + 1;
  end

  // Store capture.
  int           st_n = 0;
  logic [W-1:0] st_addr;
  logic [W-1:0] st_data;
  always @(posedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ready && bus.mem_we) begin
      st_addr <= bus.mem_addr;
      st_data <= bus.mem_wdata;
      st_n    <= st_n + 1;
    end
  end

  // Writeback log, sampled mid-cycle.
  logic [3:0]   log_addr [128];
  logic [W-1:0] log_data [128];
  logic         log_ovf  [128];
  int           wb_n = 0;
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_n < 128) begin
      log_addr[wb_n] <= wb_addr;
      log_data[wb_n] <= wb_data;
      log_ovf[wb_n]  <= ovf_flag;
      wb_n           <= wb_n + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) tb_mem[i] = 24'h700000;  // HALT everywhere
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: state got %0d expected %0d within %0d cycles", name, state, s, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_mem();
    wait_n = 0;
    rst_n  = 1'b0;
    step(2);
    checks++; if (pc !== 24'd10) begin errors++; $display("FAIL rst_pc: got %0h expected a", pc); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b expected 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 24'd10) begin errors++; $display("FAIL rst_addr: got %0h expected a", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 24'd0) begin errors++; $display("FAIL rst_we_wdata: got %b/%0h expected 0/0", bus.mem_we, bus.mem_wdata); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d expected 0", retired); end
    checks++; if (halted !== 1'b0 || ovf_flag !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_flags: got h=%b o=%b wb=%b expected 0/0/0", halted, ovf_flag, wb_valid); end
    rst_n = 1'b1;
    checks++; if (pc !== 24'd10 || bus.mem_addr !== 24'd10 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_release: got pc=%0h addr=%0h req=%b expected a/a/1", pc, bus.mem_addr, bus.mem_req); end
  endtask

  task automatic test_alu();
    clear_mem();
    tb_mem[10] = 24'h101005;  // ADDI r1,r0,5
    tb_mem[13] = 24'h011200;  // ADD  r2,r1,r1
    wait_n = 0;
    do_reset();
    step(3);
    checks++; if (state !== 3'd4 || wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb1_timing: got state=%0d wb=%b expected 4/1", state, wb_valid); end
    checks++; if (wb_addr !== 4'd1 || wb_data !== 24'd5) begin errors++; $display("FAIL alu_wb1: got r%0d=%0h expected r1=5", wb_addr, wb_data); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL alu_ret0: got %0d expected 0", retired); end
    step(1);
    checks++; if (retired !== 32'd1 || pc !== 24'd13 || state !== 3'd0 || wb_valid !== 1'b0) begin errors++; $display("FAIL alu_retire1: got ret=%0d pc=%0h st=%0d wb=%b expected 1/d/0/0", retired, pc, state, wb_valid); end
    step(3);
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd2 || wb_data !== 24'd10) begin errors++; $display("FAIL alu_wb2: got v=%b r%0d=%0h expected 1 r2=a", wb_valid, wb_addr, wb_data); end
    checks++; if (opcode !== 4'd0) begin errors++; $display("FAIL alu_opcode: got %0d expected 0", opcode); end
    step(1);
    checks++; if (retired !== 32'd2 || pc !== 24'd16) begin errors++; $display("FAIL alu_retire2: got ret=%0d pc=%0h expected 2/10", retired, pc); end
  endtask

  task automatic test_halt();
    clear_mem();  // address 10 holds HALT
    wait_n = 0;
    do_reset();
    step(3);
    checks++; if (halted !== 1'b1 || state !== 3'd5 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: got h=%b st=%0d req=%b expected 1/5/0", halted, state, bus.mem_req); end
    checks++; if (retired !== 32'd1 || pc !== 24'd10) begin errors++; $display("FAIL halt_retire: got ret=%0d pc=%0h expected 1/a", retired, pc); end
    step(10);
    checks++; if (retired !== 32'd1 || state !== 3'd5 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL halt_frozen: got ret=%0d st=%0d req=%b expected 1/5/0", retired, state, bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || halted !== 1'b0 || pc !== 24'd10 || bus.mem_req !== 1'b1 || retired !== 32'd0) begin errors++; $display("FAIL halt_reset: got st=%0d h=%b pc=%0h req=%b ret=%0d expected 0/0/a/1/0", state, halted, pc, bus.mem_req, retired); end
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_wait_states();
    int n;
    int st_base;
    clear_mem();
    tb_mem[10]   = 24'h103123;  // ADDI r3,r0,0x123
    tb_mem[13]   = 24'h303080;  // SW   r3 -> mem[r0+0x80]
    tb_mem[16]   = 24'h204081;  // LW   r4 <- mem[r0+0x81]
    tb_mem[8'h81] = 24'hABCDEF;
    wait_n = 3;
    st_base = st_n;
    do_reset();
    wait_state(3'd3, 80, "wait_sw_mem");
    n = 0;
    while (state === 3'd3 && n < 20) begin
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h80 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 24'h123) begin
        errors++;
        $display("FAIL wait_sw_stable: got req=%b addr=%0h we=%b wd=%0h expected 1/80/1/123", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
      end
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL wait_sw_cycles: got %0d expected 4", n); end
    checks++; if (st_n !== st_base + 1 || st_addr !== 24'h80 || st_data !== 24'h123) begin errors++; $display("FAIL wait_sw_store: got n=%0d addr=%0h data=%0h expected 1/80/123", st_n - st_base, st_addr, st_data); end
    wait_state(3'd3, 40, "wait_lw_mem");
    checks++; if (bus.mem_addr !== 24'h81 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL wait_lw_req: got addr=%0h we=%b expected 81/0", bus.mem_addr, bus.mem_we); end
    n = 0;
    while (wb_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd4 || wb_data !== 24'hABCDEF) begin errors++; $display("FAIL wait_lw_wb: got v=%b r%0d=%0h expected 1 r4=abcdef", wb_valid, wb_addr, wb_data); end
    step(1);
    checks++; if (retired !== 32'd3 || pc !== 24'd19) begin errors++; $display("FAIL wait_lw_retire: got ret=%0d pc=%0h expected 3/13", retired, pc); end

    // Reset while a store is waiting for ready.
    do_reset();
    wait_state(3'd3, 80, "wait_rst_mem");
    step(1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || pc !== 24'd10 || bus.mem_addr !== 24'd10 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || retired !== 32'd0) begin errors++; $display("FAIL wait_mid_reset: got st=%0d pc=%0h addr=%0h req=%b we=%b ret=%0d expected 0/a/a/1/0/0", state, pc, bus.mem_addr, bus.mem_req, bus.mem_we, retired); end
    step(1);
    rst_n  = 1'b1;
    wait_n = 0;
  endtask

  task automatic test_branch();
    clear_mem();
    tb_mem[10] = 24'h411FFF;  // BEQ r1,r1,-1 -> 10+3-4 = 9
    wait_n = 0;
    do_reset();
    step(3);
    checks++; if (pc !== 24'd9 || retired !== 32'd1 || state !== 3'd0) begin errors++; $display("FAIL br_beq_taken: got pc=%0h ret=%0d st=%0d expected 9/1/0", pc, retired, state); end

    clear_mem();
    tb_mem[10] = 24'h500005;  // BNE r0,r0,+5 -> not taken
    tb_mem[13] = 24'h600040;  // J 0x40
    tb_mem[8'h40] = 24'h101001;  // ADDI r1,r0,1
    tb_mem[8'h43] = 24'h510002;  // BNE r1,r0,+2 -> 0x43+3+8 = 0x4e
    tb_mem[8'h4e] = 24'h800000;  // NOP opcode 8
    do_reset();
    step(3);
    checks++; if (pc !== 24'd13) begin errors++; $display("FAIL br_bne_not_taken: got %0h expected d", pc); end
    step(3);
    checks++; if (pc !== 24'h40) begin errors++; $display("FAIL br_jump: got %0h expected 40", pc); end
    step(7);
    checks++; if (pc !== 24'h4e) begin errors++; $display("FAIL br_bne_taken: got %0h expected 4e", pc); end
    step(3);
    checks++; if (pc !== 24'h51 || retired !== 32'd5) begin errors++; $display("FAIL br_nop: got pc=%0h ret=%0d expected 51/5", pc, retired); end
    wait_state(3'd5, 10, "br_halt");
  endtask

  task automatic test_ovf_r0();
    int b;
    clear_mem();
    tb_mem[10] = 24'h101FFF;  // ADDI r1,r0,-1       r1 = ffffff
    tb_mem[13] = 24'h102001;  // ADDI r2,r0,1        r2 = 1
    tb_mem[16] = 24'h012307;  // SRL  r3,r1,r2       r3 = 7fffff
    tb_mem[19] = 24'h032400;  // ADD  r4,r3,r2       r4 = 800000, ovf
    tb_mem[22] = 24'h022000;  // ADD  r0,r2,r2       dropped
    tb_mem[25] = 24'h002500;  // ADD  r5,r0,r2       r5 = 1
    tb_mem[28] = 24'h042605;  // SLT  r6,r4,r2       r6 = 1
    tb_mem[31] = 24'h023701;  // SUB  r7,r2,r3       r7 = 800002
    tb_mem[34] = 24'h108018;  // ADDI r8,r0,24
    tb_mem[37] = 24'h018906;  // SLL  r9,r1,r8       r9 = 0
    wait_n = 0;
    b = wb_n;
    do_reset();
    wait_state(3'd5, 80, "ovf_halt");
    step(1);
    checks++; if (wb_n - b !== 10) begin errors++; $display("FAIL ovf_wb_count: got %0d expected 10", wb_n - b); end
    checks++; if (log_addr[b] !== 4'd1 || log_data[b] !== 24'hFFFFFF || log_ovf[b] !== 1'b0) begin errors++; $display("FAIL ovf_addi_neg: got r%0d=%0h o=%b expected r1=ffffff o=0", log_addr[b], log_data[b], log_ovf[b]); end
    checks++; if (log_addr[b+2] !== 4'd3 || log_data[b+2] !== 24'h7FFFFF || log_ovf[b+2] !== 1'b0) begin errors++; $display("FAIL ovf_srl: got r%0d=%0h o=%b expected r3=7fffff o=0", log_addr[b+2], log_data[b+2], log_ovf[b+2]); end
    checks++; if (log_addr[b+3] !== 4'd4 || log_data[b+3] !== 24'h800000 || log_ovf[b+3] !== 1'b1) begin errors++; $display("FAIL ovf_add: got r%0d=%0h o=%b expected r4=800000 o=1", log_addr[b+3], log_data[b+3], log_ovf[b+3]); end
    checks++; if (log_addr[b+4] !== 4'd0 || log_data[b+4] !== 24'd2) begin errors++; $display("FAIL r0_wb_pulse: got r%0d=%0h expected r0=2", log_addr[b+4], log_data[b+4]); end
    checks++; if (log_addr[b+5] !== 4'd5 || log_data[b+5] !== 24'd1) begin errors++; $display("FAIL r0_reads_zero: got r%0d=%0h expected r5=1", log_addr[b+5], log_data[b+5]); end
    checks++; if (log_addr[b+6] !== 4'd6 || log_data[b+6] !== 24'd1) begin errors++; $display("FAIL slt_signed: got r%0d=%0h expected r6=1", log_addr[b+6], log_data[b+6]); end
    checks++; if (log_addr[b+7] !== 4'd7 || log_data[b+7] !== 24'h800002) begin errors++; $display("FAIL sub: got r%0d=%0h expected r7=800002", log_addr[b+7], log_data[b+7]); end
    checks++; if (log_addr[b+9] !== 4'd9 || log_data[b+9] !== 24'd0) begin errors++; $display("FAIL sll_ge_width: got r%0d=%0h expected r9=0", log_addr[b+9], log_data[b+9]); end
    checks++; if (ovf_flag !== 1'b1 || retired !== 32'd11) begin errors++; $display("FAIL ovf_sticky: got o=%b ret=%0d expected 1/11", ovf_flag, retired); end
  endtask

  initial begin
    rst_n  = 1'b0;
    wait_n = 0;
    test_reset();
    test_alu();
    test_halt();
    test_wait_states();
    test_branch();
    test_ovf_r0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
